sar_logic_cs_param: RTL and testbench
=====================================

// Module: sar_logic_cs_param
// PURPOSE
//   Parametrised coarse/fine SAR controller, successor to the fixed 10-bit k=4 controller.
//   A coarse SAR resolves the top K bits (cmp_out_coarse, coarse_btm array).
//   The coarse code is then transferred into the fine array, and the fine SAR resolves the remaining N-K bits (cmp_out).
//   Adds over the fixed version:
//   - configurable sample length;
//   - continuous-conversion mode;
//   - valid/ready result handshake with sticky overrun flag.
//   Sits between the comparators/CDACs and the digital back end.
// PARAMETERS
//   N          10  total resolution in bits (N > K)
//   K          4   coarse bits (1 <= K < N)
//   SAMPLE_CYC 2   clk cycles in SAMPLE (>= 1)
// PORTS
//   clk                 in   1    system clock; all logic on rising edge
//   rst                 in   1    synchronous, active-high reset
//   cnvst               in   1    conversion request (level); sampled in IDLE/DONE
//   cont                in   1    1 = auto-restart after DONE without cnvst
//   cmp_out             in   1    fine comparator decision
//   cmp_out_coarse      in   1    coarse comparator decision
//   sar_ready           in   1    back end accepts sar
//   sar                 out  N    last accepted-into-register result
//   sar_valid           out  1    sar holds an unconsumed result
//   overrun             out  1    sticky: a result was dropped
//   eoc                 out  1    one-cycle end-of-conversion pulse (DONE)
//   busy                out  1    1 in any state except IDLE
//   cmp_clk             out  1    fine comparator clock
//   cmp_clk_coarse      out  1    coarse comparator clock
//   s_clk               out  1    bootstrap switch clock (1 = track)
//   fine_btm            out  2N   fine bottom plates; pair i = {n,p} at [2i+1:2i]
//   coarse_btm          out  2K   coarse bottom plates; pair j at [2j+1:2j]
//   fine_switch_drain   out  1    fine array drain switch
//   coarse_switch_drain out  1    coarse array drain switch
//   *_not (s_clk, fine_btm, coarse_btm, fine_switch_drain, coarse_switch_drain): exact bitwise complement, always
// BEHAVIOUR
//   Reset:
//   - state=IDLE; sar=0; sar_valid=0; overrun=0; eoc=0; busy=0.
//   - Comparator clocks and s_clk = 0; btm arrays all 0; drains = 0; *_not = ~.
//   - rst asserted mid-conversion aborts at that edge; nothing is kept.
//   States:
//   - IDLE: go to SAMPLE when cnvst=1; otherwise stay.
//   - SAMPLE (SAMPLE_CYC cycles):
//     - s_clk=1, both drains=1, all btm pairs 00.
//     - Exit to COARSE.
//   - COARSE (2 cycles per bit, MSB first, coarse bit j = K-1..0):
//     - phase0: pair j = 10 (test), cmp_clk_coarse=0.
//     - phase1: cmp_clk_coarse=1.
//     - Edge ending phase1 latches cmp_out_coarse: 1 -> pair stays 10, 0 -> pair = 01.
//     - Untested pairs stay 00.
//   - XFER (1 cycle):
//     - Fine pairs N-1..N-K load the coarse pair values.
//     - Remaining fine pairs 00; coarse_btm holds its values.
//   - FINE (2 cycles per bit, i = N-K-1..0): same two-phase scheme on fine_btm using cmp_clk and cmp_out.
//   - DONE (1 cycle): eoc=1; result register update (below).
//     - Next state is SAMPLE if cont=1 or cnvst=1, else IDLE.
//   Timing:
//   - If cnvst is sampled at edge E, eoc=1 in cycle E+SAMPLE_CYC+2N+2.
//   - Continuous-mode period = SAMPLE_CYC+2N+2 cycles.
//   - cnvst is ignored outside IDLE/DONE.
//   - cmp_clk and cmp_clk_coarse are never both 1; each is 0 outside its own phase1.
//   Result code: bit 1 for every decided pair 10; coarse bits form sar[N-1:N-K].
//   Handshake:
//   - Transfer occurs on an edge with sar_valid & sar_ready; afterwards sar_valid=0 unless DONE loads.
//   - DONE with sar_valid=0, or with a transfer on the same edge: sar <= code, sar_valid=1.
//   - DONE with sar_valid=1 and sar_ready=0: code is dropped, sar is unchanged, overrun <= 1.
//   - overrun is cleared only by rst.
//   busy = (state != IDLE).
// TESTING (N=10, K=4, SAMPLE_CYC=2)
//   - cmp_out=cmp_out_coarse=1, cnvst high 1 cycle, sar_ready=1 -> eoc at edge+24; sar=10'h3FF; sar_valid=1 for 1 cycle.
//   - Coarse decisions 1,0,1,1 and fine 0,1,0,1,0,1 ->
//     - sar=10'h2D5.
//     - In XFER, fine_btm[19:12]=8'b10_01_10_10.
//     - coarse_btm=8'b10_01_10_10.
//   - cont=1, sar_ready=0 -> first result held; second DONE sets overrun=1, sar unchanged.
//     - Then sar_ready=1 for 1 cycle -> sar_valid=0, overrun stays 1.
//   - rst pulse during FINE -> next cycle all outputs at reset values, busy=0; every *_not equals complement.
//   - Each cycle: never both comparator clocks high.
//     - s_clk=1 exactly 2 cycles per conversion.
//     - cnvst pulses mid-conversion do not shift eoc.

Source files
------------

// File: rtl/sar_logic_cs_param.sv
// Parametrised coarse/fine SAR controller: K coarse bits, code transfer, N-K fine bits,
// with configurable sampling, continuous mode and a valid/ready result register.
module sar_logic_cs_param #(
  parameter int N          = 10,
  parameter int K          = 4,
  parameter int SAMPLE_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cnvst,
  input  logic           cont,
  input  logic           cmp_out,
  input  logic           cmp_out_coarse,
  input  logic           sar_ready,
  output logic [N-1:0]   sar,
  output logic           sar_valid,
  output logic           overrun,
  output logic           eoc,
  output logic           busy,
  output logic           cmp_clk,
  output logic           cmp_clk_coarse,
  output logic           s_clk,
  output logic           s_clk_not,
  output logic [2*N-1:0] fine_btm,
  output logic [2*N-1:0] fine_btm_not,
  output logic [2*K-1:0] coarse_btm,
  output logic [2*K-1:0] coarse_btm_not,
  output logic           fine_switch_drain,
  output logic           fine_switch_drain_not,
  output logic           coarse_switch_drain,
  output logic           coarse_switch_drain_not
);

  localparam int CW = $clog2(N + SAMPLE_CYC + 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, COARSE, XFER, FINE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            phase;
  logic            start;
  logic [2*K-1:0]  coarse_dec;
  logic [2*N-1:0]  fine_dec;
  logic [N-1:0]    code;

  // Arrays with the bit under test (index cnt) resolved from the comparator.
  always_comb begin
    coarse_dec = coarse_btm;
    fine_dec   = fine_btm;
    code       = '0;
    for (int unsigned j = 0; j < K; j++)
      if (CW'(j) == cnt) coarse_dec[2*j +: 2] = cmp_out_coarse ? 2'b10 : 2'b01;
    for (int unsigned i = 0; i < N; i++) begin
      if (CW'(i) == cnt) fine_dec[2*i +: 2] = cmp_out ? 2'b10 : 2'b01;
      code[i] = (fine_btm[2*i +: 2] == 2'b10);
    end
    start = ((state == IDLE) && cnvst) || ((state == DONE) && (cont || cnvst));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      phase               <= 1'b0;
      sar                 <= '0;
      sar_valid           <= 1'b0;
      overrun             <= 1'b0;
      eoc                 <= 1'b0;
      cmp_clk             <= 1'b0;
      cmp_clk_coarse      <= 1'b0;
      s_clk               <= 1'b0;
      fine_btm            <= '0;
      coarse_btm          <= '0;
      fine_switch_drain   <= 1'b0;
      coarse_switch_drain <= 1'b0;
    end else begin
      case (state)
        SAMPLE: begin
          if (cnt == CW'(SAMPLE_CYC - 1)) begin
            state               <= COARSE;
            cnt                 <= CW'(K - 1);
            phase               <= 1'b0;
            s_clk               <= 1'b0;
            fine_switch_drain   <= 1'b0;
            coarse_switch_drain <= 1'b0;
            coarse_btm          <= (2*K)'(2'b10) << (2 * (K - 1));
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        COARSE: begin
          if (!phase) begin
            phase          <= 1'b1;
            cmp_clk_coarse <= 1'b1;
          end else begin
            phase          <= 1'b0;
            cmp_clk_coarse <= 1'b0;
            if (cnt == '0) begin
              state      <= XFER;
              coarse_btm <= coarse_dec;
              fine_btm   <= {coarse_dec, {(2*(N-K)){1'b0}}};
            end else begin
              // resolve bit cnt and open the test on bit cnt-1 in the same edge
              coarse_btm <= coarse_dec | ((2*K)'(2'b10) << {cnt - CW'(1), 1'b0});
              cnt        <= cnt - CW'(1);
            end
          end
        end
        XFER: begin
          state    <= FINE;
          cnt      <= CW'(N - K - 1);
          phase    <= 1'b0;
          fine_btm <= fine_btm | ((2*N)'(2'b10) << (2 * (N - K - 1)));
        end
        FINE: begin
          if (!phase) begin
            phase   <= 1'b1;
            cmp_clk <= 1'b1;
          end else begin
            phase   <= 1'b0;
            cmp_clk <= 1'b0;
            if (cnt == '0) begin
              state    <= DONE;
              fine_btm <= fine_dec;
              eoc      <= 1'b1;
            end else begin
              fine_btm <= fine_dec | ((2*N)'(2'b10) << {cnt - CW'(1), 1'b0});
              cnt      <= cnt - CW'(1);
            end
          end
        end
        DONE: begin
          eoc   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared entry into SAMPLE from IDLE and DONE overrides the case above.
      if (start) begin
        state               <= SAMPLE;
        cnt                 <= '0;
        s_clk               <= 1'b1;
        fine_switch_drain   <= 1'b1;
        coarse_switch_drain <= 1'b1;
        fine_btm            <= '0;
        coarse_btm          <= '0;
      end

      if (state == DONE) begin
        if (!sar_valid || sar_ready) begin
          sar       <= code;
          sar_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sar_valid && sar_ready) begin
        sar_valid <= 1'b0;
      end
    end
  end

  assign busy                    = (state != IDLE);
  assign s_clk_not               = ~s_clk;
  assign fine_btm_not            = ~fine_btm;
  assign coarse_btm_not          = ~coarse_btm;
  assign fine_switch_drain_not   = ~fine_switch_drain;
  assign coarse_switch_drain_not = ~coarse_switch_drain;

endmodule

// File: tb/tb_sar_logic_cs_param.sv
// Bench for sar_logic_cs_param: an ideal comparator answers from a target code queue;
// the result register, overrun and timing are predicted from the handshake rules.
module tb_sar_logic_cs_param;
  localparam int N  = 10;
  localparam int K  = 4;
  localparam int SC = 2;
  localparam int PERIOD = SC + 2*N + 2;

  logic clk = 1'b0, rst = 1'b1, cnvst = 1'b0, cont = 1'b0;
  logic cmp_out = 1'b0, cmp_out_coarse = 1'b0, sar_ready = 1'b0;
  logic [N-1:0] sar;
  logic sar_valid, overrun, eoc, busy, cmp_clk, cmp_clk_coarse, s_clk, s_clk_not;
  logic [2*N-1:0] fine_btm, fine_btm_not;
  logic [2*K-1:0] coarse_btm, coarse_btm_not;
  logic fine_switch_drain, fine_switch_drain_not, coarse_switch_drain, coarse_switch_drain_not;

  sar_logic_cs_param #(.N(N), .K(K), .SAMPLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .cnvst(cnvst), .cont(cont), .cmp_out(cmp_out),
    .cmp_out_coarse(cmp_out_coarse), .sar_ready(sar_ready), .sar(sar),
    .sar_valid(sar_valid), .overrun(overrun), .eoc(eoc), .busy(busy),
    .cmp_clk(cmp_clk), .cmp_clk_coarse(cmp_clk_coarse), .s_clk(s_clk),
    .s_clk_not(s_clk_not), .fine_btm(fine_btm), .fine_btm_not(fine_btm_not),
    .coarse_btm(coarse_btm), .coarse_btm_not(coarse_btm_not),
    .fine_switch_drain(fine_switch_drain), .fine_switch_drain_not(fine_switch_drain_not),
    .coarse_switch_drain(coarse_switch_drain), .coarse_switch_drain_not(coarse_switch_drain_not)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int inv_err = 0, hs_err = 0, last_eoc = -1;
  int p = N - 1, pop_c = 0, pop_f = 0, s_hi = 0, rdy_mode = 0;
  bit prev_cc = 1'b0;
  logic [N-1:0] code_q[$];
  logic [N-1:0] m_sar = '0;
  logic m_valid = 1'b0, m_ovr = 1'b0;
  logic [2*N-1:0] xfer_fine = '0;
  logic [2*K-1:0] xfer_coarse = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: observe outputs, drive inputs for the closing edge, advance the model.
  task automatic tick();
    logic [N-1:0] cur;
    cur = (code_q.size() > 0) ? code_q[0] : '0;
    if (!rst) begin
      if (cmp_clk && cmp_clk_coarse) inv_err++;
      if (s_clk_not !== ~s_clk || fine_btm_not !== ~fine_btm || coarse_btm_not !== ~coarse_btm ||
          fine_switch_drain_not !== ~fine_switch_drain ||
          coarse_switch_drain_not !== ~coarse_switch_drain) inv_err++;
      if (sar !== m_sar || sar_valid !== m_valid || overrun !== m_ovr) hs_err++;
      if (s_clk) s_hi++;
      if (prev_cc && pop_c == K && pop_f == 0) begin
        xfer_fine   = fine_btm;
        xfer_coarse = coarse_btm;
      end
    end
    prev_cc = cmp_clk_coarse;

    sar_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    cmp_out_coarse = 1'($urandom);
    cmp_out        = 1'($urandom);
    if (cmp_clk_coarse === 1'b1 || cmp_clk === 1'b1) begin
      if (p < 0) inv_err++;
      else begin
        if (cmp_clk_coarse === 1'b1) begin cmp_out_coarse = cur[p]; pop_c++; end
        else begin cmp_out = cur[p]; pop_f++; end
        p--;
      end
    end

    if (rst) begin
      m_sar = '0; m_valid = 1'b0; m_ovr = 1'b0;
      code_q.delete();
      p = N - 1; pop_c = 0; pop_f = 0; s_hi = 0; prev_cc = 1'b0;
    end else if (eoc === 1'b1) begin
      last_eoc = cyc;
      if (pop_c != K || pop_f != N - K || s_hi != SC) inv_err++;
      if (!m_valid || sar_ready) begin m_sar = cur; m_valid = 1'b1; end
      else m_ovr = 1'b1;
      if (code_q.size() > 0) void'(code_q.pop_front());
      p = N - 1; pop_c = 0; pop_f = 0; s_hi = 0;
    end else if (m_valid && sar_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_vals(input string pre);
    check({pre, "_sar"}, 64'(sar), 0);
    check({pre, "_valid"}, 64'(sar_valid), 0);
    check({pre, "_overrun"}, 64'(overrun), 0);
    check({pre, "_eoc"}, 64'(eoc), 0);
    check({pre, "_busy"}, 64'(busy), 0);
    check({pre, "_cmpclks"}, 64'({cmp_clk, cmp_clk_coarse, s_clk}), 0);
    check({pre, "_btm"}, 64'({fine_btm, coarse_btm}), 0);
    check({pre, "_drains"}, 64'({fine_switch_drain, coarse_switch_drain}), 0);
    check({pre, "_nots"}, 64'({s_clk_not, fine_btm_not, coarse_btm_not,
                              fine_switch_drain_not, coarse_switch_drain_not}),
          64'({(2*N + 2*K + 3){1'b1}}));
  endtask

  task automatic wait_eoc(input int after);
    for (int t = 0; t < 4 * PERIOD && last_eoc <= after; t++) tick();
  endtask

  // Single conversion from IDLE; returns edges from cnvst sample to the edge closing DONE.
  task automatic conv(input logic [N-1:0] c, input bit mid, output int lat);
    int s;
    code_q.push_back(c);
    s = cyc;
    cnvst = 1'b1;
    tick();
    cnvst = 1'b0;
    for (int t = 0; t < 4 * PERIOD && last_eoc <= s; t++) begin
      cnvst = mid && (t == 5 || t == 15);
      tick();
    end
    cnvst = 1'b0;
    lat = last_eoc - s;
  endtask

  initial begin
    int lat, e1;
    logic [N-1:0] c1, c2;
    @(negedge clk);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    reset_vals("reset");

    rdy_mode = 1;
    conv(10'h3FF, 1'b0, lat);
    check("eoc_latency_ones", 64'(lat), PERIOD);
    check("valid_after_done", 64'(sar_valid), 1);
    check("sar_ones", 64'(sar), 64'h3FF);
    tick();
    check("valid_one_cycle", 64'(sar_valid), 0);
    check("idle_after_done", 64'(busy), 0);

    conv(10'h2D5, 1'b0, lat);
    check("sar_2d5", 64'(sar), 64'h2D5);
    check("xfer_fine_hi", 64'(xfer_fine[2*N-1:2*(N-K)]), 64'b10_01_10_10);
    check("xfer_fine_lo", 64'(xfer_fine[2*(N-K)-1:0]), 0);
    check("xfer_coarse", 64'(xfer_coarse), 64'b10_01_10_10);

    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      conv(N'($urandom), 1'($urandom), lat);
      check("eoc_latency_rand", 64'(lat), PERIOD);
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_mode = 1; tick(); tick();
    check("model_after_random", 64'(hs_err), 0);

    rst = 1'b1; tick(); rst = 1'b0;
    reset_vals("reset2");
    rdy_mode = 0;
    cont = 1'b1;
    c1 = N'($urandom); c2 = ~c1;
    code_q.push_back(c1); code_q.push_back(c2);
    lat = cyc; cnvst = 1'b1; tick(); cnvst = 1'b0;
    wait_eoc(lat);
    e1 = last_eoc;
    check("cont_first_lat", 64'(e1 - lat), PERIOD);
    check("cont_first_valid", 64'(sar_valid), 1);
    check("cont_first_sar", 64'(sar), 64'(c1));
    cont = 1'b0;
    wait_eoc(e1);
    check("cont_period", 64'(last_eoc - e1), PERIOD);
    check("overrun_set", 64'(overrun), 1);
    check("overrun_sar_kept", 64'(sar), 64'(c1));
    rdy_mode = 1; tick(); rdy_mode = 0;
    check("drain_valid", 64'(sar_valid), 0);
    check("overrun_sticky", 64'(overrun), 1);
    check("idle_after_cont_off", 64'(busy), 0);

    code_q.push_back(N'($urandom));
    cnvst = 1'b1; tick(); cnvst = 1'b0;
    for (int t = 0; t < 4 * PERIOD && cmp_clk !== 1'b1; t++) tick();
    check("reached_fine", 64'(cmp_clk), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    reset_vals("abort");

    repeat (3) tick();
    check("invariants", 64'(inv_err), 0);
    check("model_tracking", 64'(hs_err), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
